act_pwl_pipe: RTL and testbench

Pipelined, multi-lane, piecewise-linear activation unit for the NN datapath; next generation of the combinational sigmoid approximator. Evaluates sigmoid, tanh or ReLU on LANES signed fixed-point values per beat, using shift-add slopes only (no multipliers). Sits between the neuron accumulator and the next layer's input buffer. Uses a valid/ready stream on both sides with full backpressure.

---
 rtl/act_pkg.sv | 40 ++++
 rtl/act_pwl_lane.sv | 95 +++++++++
 rtl/act_pwl_pipe.sv | 78 +++++++
 tb/tb_act_pwl_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared types and Q-format constants for the piecewise-linear activation unit.
package act_pkg;

   typedef enum logic [1:0] {
      MODE_SIG  = 2'b00,
      MODE_TANH = 2'b01,
      MODE_RELU = 2'b10,
      MODE_BYP  = 2'b11
   } act_mode_e;

   // Segment index, lowest range first; ReLU uses LO (negative) / MID only.
   typedef logic [2:0] seg_t;
   localparam seg_t SEG_LO  = 3'd0;
   localparam seg_t SEG_NL  = 3'd1;
   localparam seg_t SEG_MID = 3'd2;
   localparam seg_t SEG_PL  = 3'd3;
   localparam seg_t SEG_HI  = 3'd4;

   typedef enum logic [3:0] {
      QC_0P125, QC_0P5, QC_0P75, QC_0P875, QC_ONE, QC_0P8, QC_1P6, QC_4, QC_8
   } qconst_e;

   // floor(v * 2^frac) for each constant the segments need
   function automatic longint q_const(input int frac, input qconst_e c);
      longint one;
      one = longint'(1) <<< frac;
      case (c)
         QC_0P125: q_const = one >>> 3;
         QC_0P5:   q_const = one >>> 1;
         QC_0P75:  q_const = (one * 3) >>> 2;
         QC_0P875: q_const = (one * 7) >>> 3;
         QC_ONE:   q_const = one;
         QC_0P8:   q_const = (one * 4) / 5;
         QC_1P6:   q_const = (one * 8) / 5;
         QC_4:     q_const = one <<< 2;
         default:  q_const = one <<< 3;
      endcase
   endfunction

endpackage

// File: rtl/act_pwl_lane.sv
// One lane of the activation: segment decode (before S1) and shift-add evaluate (after S1).
module act_pwl_lane
   import act_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24
) (
   input  logic [WIDTH-1:0] dec_x_i,
   input  act_mode_e        dec_mode_i,
   output seg_t             dec_seg_o,
   input  logic [WIDTH-1:0] ev_x_i,
   input  act_mode_e        ev_mode_i,
   input  seg_t             ev_seg_i,
   output logic [WIDTH-1:0] ev_y_o,
   output logic             ev_sat_o
);

   localparam logic signed [WIDTH-1:0] K_0P125 = WIDTH'(q_const(FRAC, QC_0P125));
   localparam logic signed [WIDTH-1:0] K_0P5   = WIDTH'(q_const(FRAC, QC_0P5));
   localparam logic signed [WIDTH-1:0] K_0P75  = WIDTH'(q_const(FRAC, QC_0P75));
   localparam logic signed [WIDTH-1:0] K_0P875 = WIDTH'(q_const(FRAC, QC_0P875));
   localparam logic signed [WIDTH-1:0] K_ONE   = WIDTH'(q_const(FRAC, QC_ONE));
   localparam logic signed [WIDTH-1:0] K_0P8   = WIDTH'(q_const(FRAC, QC_0P8));
   localparam logic signed [WIDTH-1:0] K_1P6   = WIDTH'(q_const(FRAC, QC_1P6));
   localparam logic signed [WIDTH-1:0] K_4     = WIDTH'(q_const(FRAC, QC_4));
   localparam logic signed [WIDTH-1:0] K_8     = WIDTH'(q_const(FRAC, QC_8));
   // Negative thresholds mirror the positive ones so the segments stay symmetric.
   localparam logic signed [WIDTH-1:0] K_0P8N  = -K_0P8;
   localparam logic signed [WIDTH-1:0] K_1P6N  = -K_1P6;
   localparam logic signed [WIDTH-1:0] K_4N    = -K_4;
   localparam logic signed [WIDTH-1:0] K_8N    = -K_8;
   localparam logic signed [WIDTH-1:0] K_ONEN  = -K_ONE;

   logic signed [WIDTH-1:0] xd, xe, y;

   assign xd = dec_x_i;
   assign xe = ev_x_i;

   always_comb begin
      dec_seg_o = SEG_MID;
      unique case (dec_mode_i)
         MODE_SIG: begin
            if      (xd < K_8N)   dec_seg_o = SEG_LO;
            else if (xd < K_1P6N) dec_seg_o = SEG_NL;
            else if (xd < K_1P6)  dec_seg_o = SEG_MID;
            else if (xd < K_8)    dec_seg_o = SEG_PL;
            else                  dec_seg_o = SEG_HI;
         end
         MODE_TANH: begin
            if      (xd < K_4N)   dec_seg_o = SEG_LO;
            else if (xd < K_0P8N) dec_seg_o = SEG_NL;
            else if (xd < K_0P8)  dec_seg_o = SEG_MID;
            else if (xd < K_4)    dec_seg_o = SEG_PL;
            else                  dec_seg_o = SEG_HI;
         end
         MODE_RELU: dec_seg_o = xd[WIDTH-1] ? SEG_LO : SEG_MID;
         MODE_BYP:  dec_seg_o = SEG_MID;
      endcase
   end

   always_comb begin
      y        = xe;
      ev_sat_o = 1'b0;
      unique case (ev_mode_i)
         MODE_SIG: begin
            case (ev_seg_i)
               SEG_LO:  begin y = '0;    ev_sat_o = 1'b1; end
               SEG_NL:  y = K_0P125 + (xe >>> 6);
               SEG_MID: y = K_0P5   + (xe >>> 2);
               SEG_PL:  y = K_0P875 + (xe >>> 6);
               default: begin y = K_ONE; ev_sat_o = 1'b1; end
            endcase
         end
         MODE_TANH: begin
            case (ev_seg_i)
               SEG_LO:  begin y = K_ONEN; ev_sat_o = 1'b1; end
               SEG_NL:  y = (xe >>> 4) - K_0P75;
               SEG_MID: y = xe;
               SEG_PL:  y = K_0P75 + (xe >>> 4);
               default: begin y = K_ONE;  ev_sat_o = 1'b1; end
            endcase
         end
         MODE_RELU: begin
            if (ev_seg_i == SEG_LO) begin
               y        = '0;
               ev_sat_o = 1'b1;
            end
         end
         MODE_BYP: y = xe;
      endcase
   end

   assign ev_y_o = y;

endmodule

// File: rtl/act_pwl_pipe.sv
// Two-stage, multi-lane piecewise-linear activation with a valid/ready stream on both sides.
module act_pwl_pipe
   import act_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24,
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             in_mode,
   input  logic [LANES*WIDTH-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_sat
);

   localparam int STAGES = 2;

   if (WIDTH - FRAC < 5) begin : g_bad_fmt
      $error("act_pwl_pipe: WIDTH-FRAC must be >= 5 so that +/-8 is representable");
   end

   logic                           advance;
   logic [STAGES:1]                vld_pipe_q;
   act_mode_e                      in_mode_e;
   logic [LANES-1:0][WIDTH-1:0]    in_x;
   seg_t [LANES-1:0]               s1_seg_d, s1_seg_q;
   logic [LANES-1:0][WIDTH-1:0]    s1_x_q;
   act_mode_e                      s1_mode_q;
   logic [LANES-1:0][WIDTH-1:0]    s2_y_d, s2_y_q;
   logic [LANES-1:0]               s2_sat_d, s2_sat_q;

   // Whole pipe moves as one; a stalled output freezes both stages.
   assign advance   = !vld_pipe_q[STAGES] | out_ready;
   assign in_ready  = advance;
   assign in_mode_e = act_mode_e'(in_mode);
   assign in_x      = in_data;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      act_pwl_lane #(.WIDTH(WIDTH), .FRAC(FRAC)) u_lane (
         .dec_x_i    (in_x[g]),
         .dec_mode_i (in_mode_e),
         .dec_seg_o  (s1_seg_d[g]),
         .ev_x_i     (s1_x_q[g]),
         .ev_mode_i  (s1_mode_q),
         .ev_seg_i   (s1_seg_q[g]),
         .ev_y_o     (s2_y_d[g]),
         .ev_sat_o   (s2_sat_d[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe_q <= '0;
         s1_x_q     <= '0;
         s1_mode_q  <= MODE_SIG;
         s1_seg_q   <= '0;
         s2_y_q     <= '0;
         s2_sat_q   <= '0;
      end else if (advance) begin
         vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
         s1_x_q     <= in_x;
         s1_mode_q  <= in_mode_e;
         s1_seg_q   <= s1_seg_d;
         s2_y_q     <= s2_y_d;
         s2_sat_q   <= s2_sat_d;
      end
   end

   assign out_valid = vld_pipe_q[STAGES];
   assign out_data  = s2_y_q;
   assign out_sat   = s2_sat_q;

endmodule

// File: tb/tb_act_pwl_pipe.sv
// Scoreboard bench for act_pwl_pipe: real-valued reference, random stimulus and out_ready.
module tb_act_pwl_pipe;
   localparam int W = 32;
   localparam int F = 24;
   localparam int L = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid, in_ready, out_valid, out_ready;
   logic [1:0]     in_mode;
   logic [L*W-1:0] in_data, out_data;
   logic [L-1:0]   out_sat;

   act_pwl_pipe #(.WIDTH(W), .FRAC(F), .LANES(L)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat));

   always #5 clk = ~clk;

   typedef struct {
      logic [L*W-1:0] y;
      logic [L-1:0]   sat;
      logic [1:0]     mode;
      int             hs;
      bit             lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0, bad = 0, cyc = 0, n_out = 0;
   int   rdy_ctl = 1;   // 0 hold low, 1 hold high, 2 random

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         out_ready = (rdy_ctl == 2) ? 1'($urandom_range(0, 1)) : (rdy_ctl == 1);
      end
   end

   function automatic void chk(input string name, input bit ok,
                               input logic [L*W-1:0] act, input logic [L*W-1:0] req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
      end
   endfunction

   // Reference straight from the segment table, in real arithmetic.
   function automatic void model(input logic [W-1:0] xi, input logic [1:0] m,
                                 output logic [W-1:0] y, output bit s);
      real one, x, r;
      int  xs;
      xs  = int'($signed(xi));
      one = 2.0 ** F;
      x   = real'(xs) / one;
      s   = 1'b0;
      r   = 0.0;
      case (m)
         2'd0: begin
            if      (x < -8.0) begin r = 0.0; s = 1'b1; end
            else if (x < -1.6) r = 0.125 + x / 64.0;
            else if (x <  1.6) r = 0.5 + x / 4.0;
            else if (x <  8.0) r = 0.875 + x / 64.0;
            else begin r = 1.0; s = 1'b1; end
            y = W'(int'($floor(r * one)));
         end
         2'd1: begin
            if      (x < -4.0) begin r = -1.0; s = 1'b1; end
            else if (x < -0.8) r = -0.75 + x / 16.0;
            else if (x <  0.8) r = x;
            else if (x <  4.0) r = 0.75 + x / 16.0;
            else begin r = 1.0; s = 1'b1; end
            y = W'(int'($floor(r * one)));
         end
         2'd2: begin
            s = (xs < 0);
            y = (xs < 0) ? '0 : xi;
         end
         default: y = xi;
      endcase
   endfunction

   // Monitor: pops on every output handshake and checks holds while stalled.
   initial begin
      exp_t           e;
      bit             held = 1'b0, ok;
      logic [L*W-1:0] hd;
      logic [L-1:0]   hsat;
      logic signed [W-1:0] a, x;
      longint         d, tol;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else begin
            if (held)
               chk("stall_hold", out_valid && out_data == hd && out_sat == hsat, out_data, hd);
            if (out_valid && out_ready) begin
               n_out++;
               if (sb.size() == 0) begin
                  chk("unexpected_beat", 1'b0, out_data, '0);
               end else begin
                  e   = sb.pop_front();
                  ok  = 1'b1;
                  tol = (e.mode < 2) ? 1 : 0;
                  for (int i = 0; i < L; i++) begin
                     a = out_data[i*W +: W];
                     x = e.y[i*W +: W];
                     d = longint'(a) - longint'(x);
                     if (d > tol || d < -tol) ok = 1'b0;
                  end
                  chk("data", ok, out_data, e.y);
                  chk("sat", out_sat == e.sat, L*W'(out_sat), L*W'(e.sat));
                  if (e.lat) chk("latency", cyc - e.hs == 2, L*W'(cyc - e.hs), L*W'(2));
               end
            end
            held = out_valid && !out_ready;
            hd   = out_data;
            hsat = out_sat;
         end
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_beat(input logic [L*W-1:0] x, input logic [1:0] m, input bit lit,
                            input logic [L*W-1:0] ly, input logic [L-1:0] ls, input bit lat);
      exp_t e;
      bit   r, done;
      int   n, hs;
      logic [W-1:0] yl;
      bit   sl;
      if (lit) begin
         e.y = ly; e.sat = ls;
      end else begin
         for (int i = 0; i < L; i++) begin
            model(x[i*W +: W], m, yl, sl);
            e.y[i*W +: W] = yl;
            e.sat[i]      = sl;
         end
      end
      e.mode = m; e.lat = lat;
      in_valid = 1'b1; in_data = x; in_mode = m;
      n = 0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         r  = in_ready;
         hs = cyc;
         @(posedge clk);
         #1;
         if (r) begin
            e.hs = hs;
            sb.push_back(e);
            done = 1'b1;
         end else if (++n > 200) begin
            chk("accept_timeout", 1'b0, '0, '1);
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_x(input logic [1:0] m);
      if (m >= 2 || $urandom_range(0, 3) == 0) return W'($urandom);
      return W'(int'($urandom_range(0, 20 * (1 << F))) - 10 * (1 << F));
   endfunction

   task automatic rnd_beat(input bit lat);
      logic [1:0]     m;
      logic [L*W-1:0] x;
      m = 2'($urandom_range(0, 3));
      for (int i = 0; i < L; i++) x[i*W +: W] = rnd_x(m);
      send_beat(x, m, 1'b0, '0, '0, lat);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
      chk("drain", sb.size() == 0, L*W'(sb.size()), '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_data = '0; rdy_ctl = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid == 1'b0, L*W'(out_valid), '0);
      chk("reset_out_data", out_data == '0, out_data, '0);
      chk("reset_out_sat", out_sat == '0, L*W'(out_sat), '0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_reset", in_ready == 1'b1, L*W'(in_ready), L*W'(1));

      // sigmoid directed, with latency check
      send_beat({32'hF700_0000, 32'h0200_0000, 32'hFF00_0000, 32'h0000_0000}, 2'd0, 1'b1,
                {32'h0000_0000, 32'h00E8_0000, 32'h0040_0000, 32'h0080_0000}, 4'b1000, 1'b1);
      idle(4);
      // sigmoid boundaries: -8, +8, -1.6 (middle side), just below -1.6
      send_beat({32'hFE66_6666, 32'hFE66_6667, 32'h0800_0000, 32'hF800_0000}, 2'd0, 1'b1,
                {32'h0019_9999, 32'h0019_9999, 32'h0100_0000, 32'h0000_0000}, 4'b0010, 1'b0);
      send_beat({32'h0400_0000, 32'h0100_0000, 32'hFB00_0000, 32'h0080_0000}, 2'd1, 1'b1,
                {32'h0100_0000, 32'h00D0_0000, 32'hFF00_0000, 32'h0080_0000}, 4'b1010, 1'b0);
      send_beat({32'h0000_0001, 32'h0000_0000, 32'h0300_0000, 32'hFD00_0000}, 2'd2, 1'b1,
                {32'h0000_0001, 32'h0000_0000, 32'h0300_0000, 32'h0000_0000}, 4'b0001, 1'b0);
      send_beat({32'h8000_0000, 32'h7FFF_FFFF, 32'hFD00_0000, 32'h1234_5678}, 2'd3, 1'b0,
                '0, '0, 1'b0);
      // tanh boundaries via model: -4, -0.8, 0.8, just below 0.8
      send_beat({32'h00CC_CCCB, 32'h00CC_CCCC, 32'hFF33_3334, 32'hFC00_0000}, 2'd1, 1'b0,
                '0, '0, 1'b0);
      drain();

      // backpressure: 5 beats against a stalled output
      rdy_ctl = 0;
      idle(2);
      fork
         begin
            for (int i = 0; i < 5; i++) rnd_beat(1'b0);
         end
      join_none
      repeat (5) @(posedge clk);
      #1;
      chk("bp_in_ready_low", in_ready == 1'b0, L*W'(in_ready), '0);
      chk("bp_two_held", sb.size() == 2, L*W'(sb.size()), L*W'(2));
      rdy_ctl = 1;
      wait fork;
      drain();

      // random modes and random out_ready
      rdy_ctl = 2;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 7) == 0) idle(1);
         rnd_beat(1'b0);
      end
      rdy_ctl = 1;
      idle(3);
      drain();

      // reset with two beats in flight
      rdy_ctl = 0;
      idle(2);
      rnd_beat(1'b0);
      rnd_beat(1'b0);
      rst = 1'b1;
      #1;
      chk("rst_clears_out_valid", out_valid == 1'b0, L*W'(out_valid), '0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      rdy_ctl = 1;
      idle(2);
      rnd_beat(1'b1);
      drain();
      idle(3);
      chk("no_leftover", sb.size() == 0, L*W'(sb.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
